// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, immediate-extension mode codes and decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    typedef enum logic {StRun, StBubble} id_state_e;

    function automatic logic [1:0] ext_mode_of(input logic [5:0] op);
        logic [1:0] mode;
        mode = EXT_ZERO;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LW, OP_SW, OP_BEQ, OP_BNE:    mode = EXT_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:        mode = EXT_ZERO;
            OP_LUI:                          mode = EXT_LUI;
            default:                         mode = EXT_ZERO;
        endcase
        return mode;
    endfunction

    // Opcodes with no immediate field produce a zero result.
    function automatic logic imm_used(input logic [5:0] op);
        logic used;
        used = 1'b0;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: used = 1'b1;
            default:                          used = 1'b0;
        endcase
        return used;
    endfunction

    // Instructions that read rt as a source operand.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender: (raw immediate, mode) -> datapath word.
module imm_ext_unit
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (mode)
            EXT_SIGN: result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            EXT_ZERO: result = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_LUI:  result = {imm, {(DATA_W-IMM_W){1'b0}}};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/id_imm_sequencer.sv
// ID-stage sequencer: immediate extension, ID/EX slot, load-use bubble and flush handling.
// Optional stall_count output is built when ID_STALL_CNT_EN is defined.
module id_imm_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic              out_memread,
    output logic [1:0]        out_ext_mode
`ifdef ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_count
`endif
);

    logic [5:0]        in_op;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic [1:0]        in_mode;
    logic [IMM_W-1:0]  raw_imm;
    logic [DATA_W-1:0] ext_imm;

    assign in_op   = in_instr[31:26];
    assign in_rs   = in_instr[25:21];
    assign in_rt   = in_instr[20:16];
    assign in_rd   = in_instr[15:11];
    assign in_mode = ext_mode_of(in_op);
    assign raw_imm = imm_used(in_op) ? in_instr[IMM_W-1:0] : '0;

    imm_ext_unit #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_ext (
        .imm    (raw_imm),
        .mode   (in_mode),
        .result (ext_imm)
    );

    id_state_e         state_q, state_d;
    logic              last_lw_valid_q, last_lw_valid_d;
    logic [4:0]        last_lw_rt_q, last_lw_rt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_imm_q;
    logic [5:0]        out_opcode_q;
    logic [4:0]        out_rs_q, out_rt_q, out_rd_q;
    logic              out_memread_q;
    logic [1:0]        out_ext_mode_q;

    logic slot_free, hazard, xfer;

    assign slot_free = !out_valid_q || out_ready;
    assign hazard    = last_lw_valid_q && (last_lw_rt_q != 5'd0) && in_valid &&
                       ((in_rs == last_lw_rt_q) || (reads_rt(in_op) && (in_rt == last_lw_rt_q)));
    // During a flush the offer is accepted and dropped so IF/ID can drain.
    assign in_ready  = flush || (slot_free && (state_q == StRun) && !hazard);
    assign xfer      = in_valid && in_ready && !flush;

    always_comb begin
        state_d         = state_q;
        out_valid_d     = out_valid_q;
        last_lw_valid_d = last_lw_valid_q;
        last_lw_rt_d    = last_lw_rt_q;

        if (flush) begin
            state_d = StRun;
        end else if (state_q == StRun && hazard && slot_free) begin
            state_d = StBubble;
        end else if (state_q == StBubble) begin
            state_d = StRun;
        end

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_valid_d = 1'b1;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            last_lw_valid_d = 1'b0;
        end else if (xfer) begin
            last_lw_valid_d = (in_op == OP_LW);
            last_lw_rt_d    = in_rt;
        end else if (state_q == StBubble) begin
            last_lw_valid_d = 1'b0;
        end else if (out_valid_q && out_ready && out_memread_q) begin
            last_lw_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StRun;
            last_lw_valid_q <= 1'b0;
            last_lw_rt_q    <= '0;
            out_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_lw_valid_q <= last_lw_valid_d;
            last_lw_rt_q    <= last_lw_rt_d;
            out_valid_q     <= out_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm_q      <= '0;
            out_opcode_q   <= '0;
            out_rs_q       <= '0;
            out_rt_q       <= '0;
            out_rd_q       <= '0;
            out_memread_q  <= 1'b0;
            out_ext_mode_q <= EXT_ZERO;
        end else if (xfer) begin
            out_imm_q      <= ext_imm;
            out_opcode_q   <= in_op;
            out_rs_q       <= in_rs;
            out_rt_q       <= in_rt;
            out_rd_q       <= in_rd;
            out_memread_q  <= (in_op == OP_LW);
            out_ext_mode_q <= in_mode;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_imm      = out_imm_q;
    assign out_opcode   = out_opcode_q;
    assign out_rs       = out_rs_q;
    assign out_rt       = out_rt_q;
    assign out_rd       = out_rd_q;
    assign out_memread  = out_memread_q;
    assign out_ext_mode = out_ext_mode_q;

`ifdef ID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == StBubble && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_imm_sequencer.sv
// Directed self-checking bench for id_imm_sequencer (stall counter checks when ID_STALL_CNT_EN).
module tb_id_imm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic        out_memread;
    logic [1:0]  out_ext_mode;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_imm_sequencer #(
        .DATA_W (32),
        .IMM_W  (16),
        .CNT_W  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_opcode   (out_opcode),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_memread  (out_memread),
        .out_ext_mode (out_ext_mode)
`ifdef ID_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    logic [31:0] v_instr [4];
    logic [31:0] v_imm   [4];
    logic [1:0]  v_mode  [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        v_instr[0] = itype(6'b001000, 5'd1, 5'd2, 16'h8001);  // addi
        v_imm[0]   = 32'hFFFF8001; v_mode[0] = 2'd1;
        v_instr[1] = itype(6'b001101, 5'd3, 5'd4, 16'h8001);  // ori
        v_imm[1]   = 32'h00008001; v_mode[1] = 2'd0;
        v_instr[2] = itype(6'b001111, 5'd0, 5'd5, 16'h1234);  // lui
        v_imm[2]   = 32'h12340000; v_mode[2] = 2'd2;
        v_instr[3] = rtype(5'd6, 5'd7, 5'd8);                 // add
        v_imm[3]   = 32'h0;        v_mode[3] = 2'd0;

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
        #2;
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_out_imm", out_imm, 32'd0);
        check_val("rst_memread", {31'b0, out_memread}, 32'd0);
        #10 rst = 1'b0;
        #1 check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // Extension modes, issued back to back.
        for (int i = 0; i < 4; i++) begin
            in_instr = v_instr[i];
            in_valid = 1'b1;
            #1 check_val($sformatf("b2b_in_ready%0d", i), {31'b0, in_ready}, 32'd1);
            tick();
            check_val($sformatf("b2b_valid%0d", i), {31'b0, out_valid}, 32'd1);
            check_val($sformatf("b2b_imm%0d", i), out_imm, v_imm[i]);
            check_val($sformatf("b2b_mode%0d", i), {30'b0, out_ext_mode}, {30'b0, v_mode[i]});
            check_val($sformatf("b2b_fields%0d", i), {16'b0, out_opcode, out_rs, out_rt},
                      {16'b0, v_instr[i][31:16]});
        end
        check_val("b2b_rd3", {27'b0, out_rd}, 32'd8);
        in_valid = 1'b0;
        tick();
        check_val("b2b_drain", {31'b0, out_valid}, 32'd0);

        // Load-use: lw $8 then add using $8.
        in_instr = itype(6'b100011, 5'd1, 5'd8, 16'h0004);
        in_valid = 1'b1;
        tick();
        check_val("lu_lw_valid", {31'b0, out_valid}, 32'd1);
        check_val("lu_lw_memread", {31'b0, out_memread}, 32'd1);
        check_val("lu_lw_imm", out_imm, 32'd4);
        in_instr = rtype(5'd8, 5'd9, 5'd10);
        #1 check_val("lu_hazard_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check_val("lu_bubble_valid", {31'b0, out_valid}, 32'd0);
        check_val("lu_bubble_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check_val("lu_after_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef ID_STALL_CNT_EN
        check_val("lu_stall_count", stall_count, 32'd1);
`endif
        tick();
        check_val("lu_add_valid", {31'b0, out_valid}, 32'd1);
        check_val("lu_add_rd", {27'b0, out_rd}, 32'd10);
        check_val("lu_add_memread", {31'b0, out_memread}, 32'd0);
        in_valid = 1'b0;
        tick();
        check_val("lu_no_dup", {31'b0, out_valid}, 32'd0);

        // lw $0 followed by a use of $0: no hazard.
        in_instr = itype(6'b100011, 5'd1, 5'd0, 16'h0008);
        in_valid = 1'b1;
        tick();
        in_instr = rtype(5'd0, 5'd0, 5'd12);
        #1 check_val("z0_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check_val("z0_valid", {31'b0, out_valid}, 32'd1);
        check_val("z0_rd", {27'b0, out_rd}, 32'd12);
        in_valid = 1'b0;
        tick();
`ifdef ID_STALL_CNT_EN
        check_val("z0_stall_count", stall_count, 32'd1);
`endif

        // Backpressure for three cycles.
        in_instr = itype(6'b001000, 5'd1, 5'd2, 16'h0042);
        in_valid = 1'b1;
        tick();
        check_val("bp_first_imm", out_imm, 32'h42);
        out_ready = 1'b0;
        in_instr  = itype(6'b001101, 5'd3, 5'd4, 16'h0077);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("bp_in_ready%0d", i), {31'b0, in_ready}, 32'd0);
            check_val($sformatf("bp_valid%0d", i), {31'b0, out_valid}, 32'd1);
            check_val($sformatf("bp_imm%0d", i), out_imm, 32'h42);
            tick();
        end
        out_ready = 1'b1;
        #1 check_val("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check_val("bp_second_valid", {31'b0, out_valid}, 32'd1);
        check_val("bp_second_imm", out_imm, 32'h77);
        in_valid = 1'b0;
        tick();
        check_val("bp_no_dup", {31'b0, out_valid}, 32'd0);

        // Flush during a load-use hazard cycle.
        in_instr = itype(6'b100011, 5'd1, 5'd8, 16'h0004);
        in_valid = 1'b1;
        tick();
        in_instr = rtype(5'd8, 5'd9, 5'd13);
        flush    = 1'b1;
        #1 check_val("fl_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        flush = 1'b0;
        check_val("fl_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef ID_STALL_CNT_EN
        check_val("fl_stall_count", stall_count, 32'd1);
`endif
        in_instr = rtype(5'd8, 5'd9, 5'd14);
        #1 check_val("fl_run_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check_val("fl_next_valid", {31'b0, out_valid}, 32'd1);
        check_val("fl_next_rd", {27'b0, out_rd}, 32'd14);
        in_valid = 1'b0;
        tick();
        check_val("fl_drain", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset while in the bubble.
        in_instr = itype(6'b100011, 5'd1, 5'd8, 16'h0004);
        in_valid = 1'b1;
        tick();
        in_instr = rtype(5'd8, 5'd9, 5'd15);
        tick();
        check_val("mb_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check_val("mb_rst_valid", {31'b0, out_valid}, 32'd0);
        check_val("mb_rst_imm", out_imm, 32'd0);
`ifdef ID_STALL_CNT_EN
        check_val("mb_rst_stall_count", stall_count, 32'd0);
`endif
        #1 rst = 1'b0;
        #1 check_val("mb_release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check_val("mb_issue_valid", {31'b0, out_valid}, 32'd1);
        check_val("mb_issue_rd", {27'b0, out_rd}, 32'd15);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_imm_sequencer.md
Name: id_imm_sequencer

Overview:
ID-stage sequencer that owns the immediate-extension path of the 5-stage MIPS pipeline.
- Accepts decoded-instruction words from IF/ID over a valid/ready handshake.
- Picks the extension mode from the opcode and registers the 32-bit immediate plus operand fields into the ID/EX slot.
- Inserts a one-cycle bubble on load-use hazards and honours branch/jump flushes from EX.

Parameters:
- DATA_W, 32, width of extended immediate and datapath word
- IMM_W, 16, width of raw instruction immediate
- CNT_W, 32, width of stall counter (optional feature only)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  IF/ID holds a valid instruction
- in_instr  input  32  instruction word
- in_ready  output  1  ID accepts in_instr this cycle
- flush  input  1  synchronous squash of ID and ID/EX slot (taken branch/jump)
- out_valid  output  1  ID/EX slot holds a valid instruction
- out_ready  input  1  EX consumes the slot this cycle
- out_imm  output  DATA_W  extended immediate
- out_opcode  output  6  instr[31:26]
- out_rs  output  5  instr[25:21]
- out_rt  output  5  instr[20:16]
- out_rd  output  5  instr[15:11]
- out_memread  output  1  slot is lw
- out_ext_mode  output  2  mode used (ZERO=0, SIGN=1, LUI=2)

Behaviour:
- Reset (async, any time, including mid-bubble): out_valid=0; all out_* data=0; state=RUN; last_lw_valid=0.
- Extension mode by opcode:
  - SIGN: addi 001000, addiu 001001, slti 001010, sltiu 001011, lw 100011, sw 101011, beq 000100, bne 000101. Result is {16{imm[15]},imm}.
  - ZERO: andi 001100, ori 001101, xori 001110. Result is {16'h0,imm}.
  - LUI: 001111. Result is {imm,16'h0}.
  - R-type (000000) and all others: ZERO mode, result is 32'h0.
- Latency: 1 cycle. The instruction accepted at edge N appears on out_* after edge N.
- Slot rules:
  - Slot is free when out_valid=0 or out_ready=1.
  - in_ready = slot free AND state==RUN AND no hazard.
  - Transfer occurs when in_valid & in_ready. The slot then loads the new instruction with out_valid=1.
  - If the slot is consumed and nothing is transferred, out_valid goes to 0.
  - If the slot is not free, all out_* hold stable.
- Hazard check uses the last transferred instruction, tracked as last_lw_valid/last_lw_rt:
  - Hazard when last_lw_valid, last_lw_rt!=0, and in_valid.
  - It also requires in.rs==last_lw_rt, or in.rt==last_lw_rt for R-type/sw/beq/bne.
  - last_lw_valid clears once that lw has been consumed by EX.
- FSM states:
  - RUN → BUBBLE on hazard while the slot is free. Takes no transfer; out_valid=0 next cycle.
  - BUBBLE → RUN after exactly one cycle. in_ready=0 in BUBBLE; last_lw_valid cleared on exit.
- flush has priority over everything except reset:
  - Next cycle out_valid=0, state=RUN, last_lw_valid=0.
  - in_ready=1 that cycle, and the offered instruction is discarded.
- Simultaneous consume and transfer is a normal full-throughput case.
- Simultaneous hazard and flush: flush wins, and no bubble is counted.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- When defined:
  - Adds output stall_count [CNT_W-1:0], reset 0.
  - Increments on every cycle in BUBBLE state.
  - Saturates at all-ones; no wrap.
- When undefined: port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI … OP_SW)
  - ext mode codes EXT_ZERO/EXT_SIGN/EXT_LUI
  - the opcode→mode decode function
- One natural sub-module: imm_ext_unit, a combinational (imm, mode)→32-bit result. It is instantiated once ahead of the ID/EX register.
- FSM, hazard tracking and slot register live in id_imm_sequencer.

Test Plan:
- Reset mid-BUBBLE: assert rst asynchronously → out_valid=0 and out_imm=0 immediately; in_ready=1 on the first edge after release.
- Extension modes:
  - addi imm=16'h8001 → out_imm=32'hFFFF8001, mode=1.
  - ori imm=16'h8001 → 32'h00008001.
  - lui 16'h1234 → 32'h12340000.
  - R-type → 32'h0.
- Back-to-back throughput: 4 independent instrs, out_ready=1 → 4 consecutive out_valid cycles, 1-cycle latency, in order.
- Load-use: lw $t0 then add rs=$t0 → exactly one bubble (out_valid=0 one cycle, in_ready=0); add issues next; stall_count=1 with ID_STALL_CNT_EN. lw $0 then use $0 → no bubble.
- Backpressure: out_ready=0 for 3 cycles with valid slot → out_* stable, in_ready=0; releases with no loss or duplication.
- Flush: flush during a hazard cycle with in_valid=1 → next cycle out_valid=0, state RUN, no bubble counted, and the offered instr is never emitted.
